// File: rtl/nvram_ioctl_bridge_if.sv
// nvram_ioctl_bridge_if: ioctl channel and shared NVRAM port signals of the bridge
interface nvram_ioctl_bridge_if #(
   parameter int ADDR_W = 11
);
   logic              ioctl_download;
   logic              ioctl_upload;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic              ioctl_rd;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [7:0]        ioctl_din;
   logic              ioctl_wait;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_d;
   logic [7:0]        ram_q;
   logic              ram_busy;
   logic              cpu_ram_we;
   logic              nvram_dirty;
   modport slave (
      input  ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_rd, ioctl_addr, ioctl_dout,
      input  ram_q, ram_busy, cpu_ram_we,
      output ioctl_din, ioctl_wait, ram_addr, ram_we, ram_d, nvram_dirty
   );
   modport master (
      output ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_rd, ioctl_addr, ioctl_dout,
      output ram_q, ram_busy, cpu_ram_we,
      input  ioctl_din, ioctl_wait, ram_addr, ram_we, ram_d, nvram_dirty
   );
endinterface

// File: rtl/nvram_ioctl_bridge.sv
// nvram_ioctl_bridge: HPS ioctl save/load responder on a CPU-priority NVRAM port; define NVRAM_DIRTY_EN for the dirty flag
module nvram_ioctl_bridge #(
   parameter int         ADDR_W = 11,
   parameter logic [7:0] INDEX  = 8'd4
) (
   input logic                 clk_sys,
   input logic                 reset,
   nvram_ioctl_bridge_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} state_t;
   state_t            r_state;
   logic [7:0]        r_din;
   logic [7:0]        r_d;
   logic [ADDR_W-1:0] r_addr;
   logic              w_sel;
   logic              w_oor;
   logic              w_wr;
   logic              w_rd;
   assign w_sel = bus.ioctl_index == INDEX;
   assign w_oor = |bus.ioctl_addr[24:ADDR_W];
   assign w_wr  = w_sel & bus.ioctl_download & bus.ioctl_wr;
   assign w_rd  = w_sel & bus.ioctl_upload & bus.ioctl_rd;
   assign bus.ioctl_wait = (r_state != IDLE) | (r_state == IDLE & (w_wr | w_rd));
   assign bus.ram_we     = (r_state == WR_REQ) & ~bus.ram_busy;
   assign bus.ioctl_din  = r_din;
   assign bus.ram_addr   = r_addr;
   assign bus.ram_d      = r_d;
   // transfer sequencer: accept a strobe in IDLE, wait out CPU ownership, then write or fetch one byte
   always_ff @(posedge clk_sys)
      if (reset) begin
         r_state <= IDLE;
         r_din   <= 8'hFF;
         r_addr  <= '0;
         r_d     <= '0;
      end else case (r_state)
         IDLE:
            if (w_wr) begin
               if (!w_oor) begin
                  r_addr  <= bus.ioctl_addr[ADDR_W-1:0];
                  r_d     <= bus.ioctl_dout;
                  r_state <= WR_REQ;
               end
            end else if (w_rd) begin
               if (w_oor) r_din <= 8'hFF;
               else begin
                  r_addr  <= bus.ioctl_addr[ADDR_W-1:0];
                  r_state <= RD_REQ;
               end
            end
         RD_REQ:  r_state <= bus.ram_busy ? RD_REQ : RD_DATA;
         RD_DATA: begin
            r_din   <= bus.ram_q;
            r_state <= IDLE;
         end
         WR_REQ:  r_state <= bus.ram_busy ? WR_REQ : IDLE;
      endcase
`ifdef NVRAM_DIRTY_EN
   logic r_up;
   logic r_dn;
   logic r_dirty;
   logic w_done;
   assign w_done = w_sel & (r_up & ~bus.ioctl_upload | r_dn & ~bus.ioctl_download);
   assign bus.nvram_dirty = r_dirty;
   // dirty flag: CPU writes set it, a finished session for this index clears it, set wins
   always_ff @(posedge clk_sys)
      if (reset) begin
         r_up    <= 1'b0;
         r_dn    <= 1'b0;
         r_dirty <= 1'b0;
      end else begin
         r_up    <= bus.ioctl_upload;
         r_dn    <= bus.ioctl_download;
         r_dirty <= bus.cpu_ram_we | (r_dirty & ~w_done);
      end
`else
   logic w_unused;
   assign w_unused = bus.cpu_ram_we;
   assign bus.nvram_dirty = 1'b0;
`endif
endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// tb_nvram_ioctl_bridge: directed stimulus against a transaction-level model of the ioctl NVRAM bridge
module tb_nvram_ioctl_bridge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   w;
   int   e;
`ifdef NVRAM_DIRTY_EN
   localparam logic DEN = 1'b1;
`else
   localparam logic DEN = 1'b0;
`endif
   always #5 clk = ~clk;
   nvram_ioctl_bridge_if #(.ADDR_W(11)) bus ();
   nvram_ioctl_bridge #(.ADDR_W(11), .INDEX(8'd4)) dut (
      .clk_sys(clk),
      .reset  (rst),
      .bus    (bus)
   );
   logic [7:0] ram [0:2047] = '{default: 8'h00};
   // NVRAM port as the game RAM presents it: synchronous write, one-cycle registered read
   always @(posedge clk) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_d;
      bus.ram_q <= ram[bus.ram_addr];
   end
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      tests++;
      if (a !== x) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
      end
   endtask
   logic [7:0]  mmem [0:2047] = '{default: 8'h00};
   int          m_free = 0;
   int          m_tail = 0;
   bit          m_write = 0;
   int          m_addr = 0;
   logic [7:0]  m_data = 0;
   logic [7:0]  m_din = 8'hFF;
   bit          m_dirty = 0;
   bit          m_pu = 0;
   bit          m_pd = 0;
   bit          armed = 0;
   // model: an accepted op needs one CPU-free cycle, reads one more cycle for data; check every cycle
   always @(negedge clk) begin
      bit pend, sel, oor, acc_w, acc_r, x_we, fall;
      pend  = m_free > 0 || m_tail > 0;
      sel   = bus.ioctl_index == 8'd4;
      oor   = bus.ioctl_addr >= 25'd2048;
      acc_w = !pend && sel && bus.ioctl_download && bus.ioctl_wr;
      acc_r = !pend && sel && bus.ioctl_upload && bus.ioctl_rd && !acc_w;
      x_we  = pend && m_free > 0 && m_write && !bus.ram_busy;
      if (armed) begin
         chk("wait", bus.ioctl_wait, pend || acc_w || acc_r);
         chk("ram_we", bus.ram_we, x_we);
         if (x_we) begin
            chk("ram_addr", bus.ram_addr, m_addr);
            chk("ram_d", bus.ram_d, m_data);
         end
         chk("din", bus.ioctl_din, m_din);
         chk("dirty", bus.nvram_dirty, m_dirty);
      end
      if (rst) begin
         m_free = 0; m_tail = 0; m_din = 8'hFF; m_dirty = 0; m_pu = 0; m_pd = 0;
         armed = 1;
      end else begin
         if (pend) begin
            if (m_free > 0) begin
               if (!bus.ram_busy) begin
                  m_free--;
                  if (m_write) mmem[m_addr] = m_data;
               end
            end else begin
               m_tail--;
               if (m_tail == 0) m_din = mmem[m_addr];
            end
         end else if (acc_w) begin
            if (!oor) begin
               m_write = 1; m_free = 1; m_tail = 0;
               m_addr = int'(bus.ioctl_addr); m_data = bus.ioctl_dout;
            end
         end else if (acc_r) begin
            if (oor) m_din = 8'hFF;
            else begin
               m_write = 0; m_free = 1; m_tail = 1; m_addr = int'(bus.ioctl_addr);
            end
         end
         fall = sel && ((m_pu && !bus.ioctl_upload) || (m_pd && !bus.ioctl_download));
         m_dirty = DEN && (bus.cpu_ram_we || (m_dirty && !fall));
         m_pu = bus.ioctl_upload;
         m_pd = bus.ioctl_download;
      end
   end
   task automatic xfer(input bit wr, input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                       input int busy_n, output int waits, output int wes);
      bit done;
      waits = 0; wes = 0; done = 0;
      @(posedge clk) #1;
      bus.ioctl_index = idx; bus.ioctl_addr = a; bus.ioctl_dout = d;
      bus.ioctl_wr = wr; bus.ioctl_rd = !wr; bus.ram_busy = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (!bus.ioctl_wait) done = 1;
         else begin
            waits++;
            if (bus.ram_we) wes++;
            @(posedge clk) #1;
            bus.ioctl_wr = 1'b0; bus.ioctl_rd = 1'b0; bus.ram_busy = c < busy_n;
         end
      end
      chk("xfer_timeout", done, 1'b1);
      @(posedge clk) #1;
      bus.ioctl_wr = 1'b0; bus.ioctl_rd = 1'b0; bus.ram_busy = 1'b0; bus.ioctl_index = 8'd4;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.ioctl_download = 0; bus.ioctl_upload = 0; bus.ioctl_index = 8'd4;
      bus.ioctl_wr = 0; bus.ioctl_rd = 0; bus.ioctl_addr = 0; bus.ioctl_dout = 0;
      bus.ram_busy = 0; bus.cpu_ram_we = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_wait", bus.ioctl_wait, 1'b0);
      chk("reset_din", bus.ioctl_din, 8'hFF);
      chk("reset_we", bus.ram_we, 1'b0);
      chk("reset_addr", bus.ram_addr, 11'h000);
      chk("reset_dirty", bus.nvram_dirty, 1'b0);
      @(posedge clk) #1 bus.ioctl_download = 1;
      xfer(1, 8'd4, 25'h005, 8'hA5, 0, w, e);
      chk("wr_waits", w, 2); chk("wr_we", e, 1);
      xfer(1, 8'd4, 25'h123, 8'h5A, 4, w, e);
      chk("wr_busy_waits", w, 6); chk("wr_busy_we", e, 1);
      xfer(1, 8'd4, 25'h800, 8'h77, 0, w, e);
      chk("wr_oor_waits", w, 1); chk("wr_oor_we", e, 0);
      xfer(1, 8'd0, 25'h006, 8'h11, 0, w, e);
      chk("wr_idx0_waits", w, 0); chk("wr_idx0_we", e, 0);
      xfer(0, 8'd4, 25'h005, 8'h00, 0, w, e);
      chk("rd_wrong_session_waits", w, 0);
      @(posedge clk) #1 bus.ioctl_download = 0;
      @(posedge clk) #1 bus.ioctl_upload = 1;
      xfer(0, 8'd4, 25'h005, 8'h00, 0, w, e);
      chk("rd_waits", w, 3); chk("rd_we", e, 0); chk("rd_din", bus.ioctl_din, 8'hA5);
      xfer(0, 8'd4, 25'h123, 8'h00, 2, w, e);
      chk("rd_busy_waits", w, 5); chk("rd_busy_din", bus.ioctl_din, 8'h5A);
      @(posedge clk) #1;
      bus.ioctl_download = 1; bus.ioctl_addr = 25'h010; bus.ioctl_dout = 8'h3C; bus.ioctl_wr = 1;
      @(posedge clk) #1;
      bus.ioctl_wr = 0; bus.ram_busy = 1;
      @(posedge clk) #1 rst = 1;
      @(posedge clk) #1 rst = 0;
      @(negedge clk);
      chk("rst_mid_wait", bus.ioctl_wait, 1'b0);
      chk("rst_mid_we", bus.ram_we, 1'b0);
      chk("rst_mid_din", bus.ioctl_din, 8'hFF);
      @(posedge clk) #1 bus.ram_busy = 0;
      @(posedge clk) #1 bus.ioctl_download = 0;
      xfer(0, 8'd4, 25'h010, 8'h00, 0, w, e);
      chk("rd_after_rst_din", bus.ioctl_din, 8'h00);
      xfer(0, 8'd4, 25'h123, 8'h00, 0, w, e);
      xfer(0, 8'd4, 25'h800, 8'h00, 0, w, e);
      chk("rd_oor_waits", w, 1); chk("rd_oor_din", bus.ioctl_din, 8'hFF);
      xfer(0, 8'd0, 25'h005, 8'h00, 0, w, e);
      chk("rd_idx0_waits", w, 0); chk("rd_idx0_din", bus.ioctl_din, 8'hFF);
      @(posedge clk) #1 bus.ioctl_upload = 0;
      @(posedge clk) #1 bus.cpu_ram_we = 1;
      @(posedge clk) #1 bus.cpu_ram_we = 0;
      @(negedge clk) chk("dirty_set", bus.nvram_dirty, DEN);
      @(posedge clk) #1 bus.ioctl_upload = 1;
      @(posedge clk) #1 bus.ioctl_upload = 0;
      @(posedge clk) #1;
      @(negedge clk) chk("dirty_clear", bus.nvram_dirty, 1'b0);
      @(posedge clk) #1 bus.cpu_ram_we = 1;
      @(posedge clk) #1 bus.cpu_ram_we = 0;
      @(posedge clk) #1 bus.ioctl_upload = 1;
      @(posedge clk) #1;
      bus.ioctl_upload = 0; bus.cpu_ram_we = 1;
      @(posedge clk) #1 bus.cpu_ram_we = 0;
      @(negedge clk) chk("dirty_set_wins", bus.nvram_dirty, DEN);
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
